// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, NOP encoding and sequencer FSM states shared by the core
package riscv_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/hazard_ctrl_unit_hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the source registers read in ID
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       MemRead_EX,
  input  logic [4:0] RD_EX,
  input  logic [4:0] RS1_ID,
  input  logic [4:0] RS2_ID,
  input  logic [6:0] OPCODE_ID,
  output logic       load_use
);
  logic uses_rs1, uses_rs2;
  // only a real source field may match; x0 is never a dependency
  always_comb begin
    uses_rs1 = !(OPCODE_ID inside {OP_LUI, OP_AUIPC, OP_JAL});
    uses_rs2 = OPCODE_ID inside {OP_R, OP_S, OP_B};
    load_use = MemRead_EX && (RD_EX != 5'd0) &&
               ((uses_rs1 && RD_EX == RS1_ID) || (uses_rs2 && RD_EX == RS2_ID));
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencer producing stage enables, flushes, bubbles and stall statistics
module hazard_ctrl_unit
  import riscv_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [6:0]       OPCODE_ID,
  input  logic             PCSrc_EX,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic load_use, br, lu, stall;
  hazard_detect u_hd (
    .MemRead_EX(MemRead_EX),
    .RD_EX     (RD_EX),
    .RS1_ID    (RS1_ID),
    .RS2_ID    (RS2_ID),
    .OPCODE_ID (OPCODE_ID),
    .load_use  (load_use)
  );
  // priority mux mem_busy > branch > load-use > normal; reset forces a bubble with everything frozen
  always_comb begin
    br           = PCSrc_EX && !mem_busy;
    lu           = load_use && !mem_busy && !PCSrc_EX;
    stall        = mem_busy || lu;
    state_nxt    = mem_busy ? MEM_WAIT : RUN;
    wait_nxt     = !mem_busy ? '0 :
                   state == RUN ? WW'(1) :
                   wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + WW'(1);
    PC_write     = reset && !stall;
    IF_ID_write  = reset && !stall;
    IF_ID_flush  = reset && br;
    ID_EX_bubble = !reset || br || lu;
    pipe_hold    = reset && mem_busy;
  end
  // state, wait length, sticky timeout and saturating perf counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout || (wait_nxt == WW'(MAX_WAIT));
      stall_cnt   <= stall_cnt + CNT_W'(stall && !(&stall_cnt));
      flush_cnt   <= flush_cnt + CNT_W'(br && !(&flush_cnt));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed scoreboard bench for the pipeline sequencer
module tb_hazard_ctrl_unit;
  import riscv_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic MemRead_EX = 1'b0, PCSrc_EX = 1'b0, mem_busy = 1'b0;
  logic [4:0] RD_EX = '0, RS1_ID = '0, RS2_ID = '0;
  logic [6:0] OPCODE_ID = OP_I;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  localparam logic [4:0] NORM = 5'b11000, STALL = 5'b00010, FLUSH = 5'b11110, HOLD = 5'b00001;
  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  int m_sc = 0, m_fc = 0, m_run = 0;
  logic m_to = 1'b0;
  hazard_ctrl_unit #(.CNT_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID),
    .RS2_ID(RS2_ID), .OPCODE_ID(OPCODE_ID), .PCSrc_EX(PCSrc_EX), .mem_busy(mem_busy),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [6:0] op, input logic b, input logic mb,
                      input logic [4:0] ctl_exp);
    exp_t e;
    MemRead_EX = mr; RD_EX = rd; RS1_ID = rs1; RS2_ID = rs2; OPCODE_ID = op;
    PCSrc_EX = b; mem_busy = mb;
    if (!ctl_exp[4]) m_sc++;
    if (ctl_exp[2]) m_fc++;
    m_run = mb ? m_run + 1 : 0;
    if (m_run >= 15) m_to = 1'b1;
    q.push_back('{tag, ctl_exp, 16'(m_sc), 16'(m_fc), m_to});
    #2;
    e = q.pop_front();
    chk({e.tag, ".ctl"}, {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold}, e.ctl);
    @(posedge clk);
    #1;
    chk({e.tag, ".stall_cnt"}, stall_cnt, e.sc);
    chk({e.tag, ".flush_cnt"}, flush_cnt, e.fc);
    chk({e.tag, ".timeout"}, mem_timeout, e.to);
  endtask
  initial begin
    #2;
    chk("rst0.ctl", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold}, STALL);
    chk("rst0.stall_cnt", stall_cnt, 0);
    chk("rst0.flush_cnt", flush_cnt, 0);
    chk("rst0.timeout", mem_timeout, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step("normal",    0, 0, 0, 0, OP_I,   0, 0, NORM);
    step("lu_rs2_R",  1, 5, 1, 5, OP_R,   0, 0, STALL);
    step("lu_clear",  0, 5, 1, 5, OP_R,   0, 0, NORM);
    step("rs2_I",     1, 5, 1, 5, OP_I,   0, 0, NORM);
    step("lu_rs1_I",  1, 5, 5, 1, OP_I,   0, 0, STALL);
    step("lui_rs1",   1, 5, 5, 1, OP_LUI, 0, 0, NORM);
    step("x0",        1, 0, 0, 0, OP_R,   0, 0, NORM);
    step("br_lu",     1, 5, 1, 5, OP_R,   1, 0, FLUSH);
    step("busy1",     0, 0, 0, 0, OP_I,   0, 1, HOLD);
    step("busy2",     0, 0, 0, 0, OP_I,   0, 1, HOLD);
    step("busy3",     0, 0, 0, 0, OP_I,   0, 1, HOLD);
    reset = 1'b0;
    #1;
    chk("rst_wait.ctl", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold}, STALL);
    chk("rst_wait.stall_cnt", stall_cnt, 0);
    chk("rst_wait.flush_cnt", flush_cnt, 0);
    @(posedge clk);
    #1;
    chk("rst_hold.stall_cnt", stall_cnt, 0);
    mem_busy = 1'b0;
    reset = 1'b1;
    m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
    step("post_rst",  0, 0, 0, 0, OP_I,   0, 0, NORM);
    for (int i = 0; i < 3; i++) step("busy3x", 0, 0, 0, 0, OP_I, 0, 1, HOLD);
    step("release",   0, 0, 0, 0, OP_I,   0, 0, NORM);
    step("busy_br",   0, 0, 0, 0, OP_I,   1, 1, HOLD);
    step("br_after",  0, 0, 0, 0, OP_I,   1, 0, FLUSH);
    for (int i = 0; i < 15; i++) step("busy15", 0, 0, 0, 0, OP_I, 0, 1, HOLD);
    step("rel_to",    0, 0, 0, 0, OP_I,   0, 0, NORM);
    step("to_sticky", 1, 7, 7, 0, OP_B,   0, 0, STALL);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
